// File: rtl/button_frontend.sv
// Push-button conditioner: synchronizes and debounces eight raw inputs, emits one-cycle
// press pulses with auto-repeat on bits 0-2, and cycles the clock/timer mode registers.
module button_frontend #(
    parameter int M_FREQ      = 20000000,
    parameter int DEBOUNCE_MS = 10,
    parameter int HOLD_MS     = 600,
    parameter int REPEAT_MS   = 200
) (
    input  logic       mclk,
    input  logic       rst_n,
    input  logic [5:0] pButton,
    input  logic       pMode,
    input  logic       pTimer,
    output logic [5:0] vButton,
    output logic [1:0] clk_mode,
    output logic [1:0] timer_mode,
    output logic [5:0] dbg_rpt_state
);

    // Products are formed in 64 bits so large M_FREQ values cannot overflow.
    localparam longint DB_PROD  = longint'(M_FREQ) * longint'(DEBOUNCE_MS) / 1000;
    localparam longint HLD_PROD = longint'(M_FREQ) * longint'(HOLD_MS) / 1000;
    localparam longint RPT_PROD = longint'(M_FREQ) * longint'(REPEAT_MS) / 1000;

    localparam logic [31:0] DB_CYCLES     = (DB_PROD  < 1) ? 32'd1 : 32'(DB_PROD);
    localparam logic [31:0] HOLD_CYCLES   = (HLD_PROD < 1) ? 32'd1 : 32'(HLD_PROD);
    localparam logic [31:0] REPEAT_CYCLES = (RPT_PROD < 1) ? 32'd1 : 32'(RPT_PROD);

    localparam logic [31:0] DB_LAST  = DB_CYCLES - 32'd1;
    localparam logic [31:0] HLD_LAST = HOLD_CYCLES - 32'd1;
    localparam logic [31:0] RPT_LAST = REPEAT_CYCLES - 32'd1;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_HOLD   = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    // Channel order: [5:0] pButton, [6] pMode, [7] pTimer.
    logic [7:0]       raw;
    logic [7:0]       sync1_q, sync1_d;
    logic [7:0]       sync2_q, sync2_d;
    logic [7:0]       lvl_q, lvl_d;
    logic [7:0][31:0] dcnt_q, dcnt_d;
    logic [2:0][31:0] rcnt_q, rcnt_d;
    rpt_state_e       state_q [3];
    rpt_state_e       state_d [3];
    logic [7:0]       press;
    logic [2:0]       fall;
    logic [2:0]       rpt_pulse;
    logic [5:0]       vbutton_q, vbutton_d;
    logic             mode_press_q, mode_press_d;
    logic             timer_press_q, timer_press_d;
    logic [1:0]       clk_mode_q, clk_mode_d;
    logic [1:0]       timer_mode_q, timer_mode_d;

    always_comb begin
        raw     = {pTimer, pMode, pButton};
        sync1_d = raw;
        sync2_d = sync1_q;
        lvl_d   = lvl_q;
        dcnt_d  = '0;
        for (int i = 0; i < 8; i++) begin
            if (sync2_q[i] != lvl_q[i]) begin
                if (dcnt_q[i] == DB_LAST) begin
                    lvl_d[i] = ~lvl_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 32'd1;
                end
            end
        end
        press = lvl_d & ~lvl_q;
        fall  = lvl_q[2:0] & ~lvl_d[2:0];
    end

    // Release wins over a repeat pulse that would land on the same edge.
    always_comb begin
        rcnt_d    = rcnt_q;
        rpt_pulse = '0;
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            if (fall[i]) begin
                state_d[i] = RPT_IDLE;
                rcnt_d[i]  = '0;
            end else begin
                case (state_q[i])
                    RPT_IDLE: begin
                        if (press[i]) begin
                            state_d[i] = RPT_HOLD;
                            rcnt_d[i]  = '0;
                        end
                    end
                    RPT_HOLD: begin
                        if (rcnt_q[i] == HLD_LAST) begin
                            rpt_pulse[i] = 1'b1;
                            rcnt_d[i]    = '0;
                            state_d[i]   = RPT_REPEAT;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + 32'd1;
                        end
                    end
                    RPT_REPEAT: begin
                        if (rcnt_q[i] == RPT_LAST) begin
                            rpt_pulse[i] = 1'b1;
                            rcnt_d[i]    = '0;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + 32'd1;
                        end
                    end
                    default: begin
                        state_d[i] = RPT_IDLE;
                        rcnt_d[i]  = '0;
                    end
                endcase
            end
        end
    end

    // Mode registers act on the registered press, one cycle after lvl rises.
    always_comb begin
        vbutton_d     = press[5:0] | {3'b000, rpt_pulse};
        mode_press_d  = press[6];
        timer_press_d = press[7];
        clk_mode_d    = clk_mode_q;
        timer_mode_d  = timer_mode_q;
        if (mode_press_q && (timer_mode_q == 2'd0)) begin
            clk_mode_d = clk_mode_q + 2'd1;
        end else if (timer_press_q && (clk_mode_q == 2'd0)) begin
            timer_mode_d = (timer_mode_q == 2'd2) ? 2'd0 : timer_mode_q + 2'd1;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            lvl_q         <= '0;
            dcnt_q        <= '0;
            rcnt_q        <= '0;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= RPT_IDLE;
            end
            vbutton_q     <= '0;
            mode_press_q  <= 1'b0;
            timer_press_q <= 1'b0;
            clk_mode_q    <= '0;
            timer_mode_q  <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            lvl_q         <= lvl_d;
            dcnt_q        <= dcnt_d;
            rcnt_q        <= rcnt_d;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
            end
            vbutton_q     <= vbutton_d;
            mode_press_q  <= mode_press_d;
            timer_press_q <= timer_press_d;
            clk_mode_q    <= clk_mode_d;
            timer_mode_q  <= timer_mode_d;
        end
    end

    assign vButton       = vbutton_q;
    assign clk_mode      = clk_mode_q;
    assign timer_mode    = timer_mode_q;
    assign dbg_rpt_state = {state_q[2], state_q[1], state_q[0]};

endmodule

// File: tb/tb_button_frontend.sv
// Scoreboard bench for button_frontend: expected {edge, vButton} pulses are queued as
// stimulus is driven and matched by a monitor; mode outputs are checked against a small model.
module tb_button_frontend;

    logic       mclk;
    logic       rst_n;
    logic [5:0] pButton;
    logic       pMode;
    logic       pTimer;
    logic [5:0] vButton;
    logic [1:0] clk_mode;
    logic [1:0] timer_mode;
    logic [5:0] dbg_rpt_state;

    int          cyc;
    int          n_cmp;
    int          n_err;
    logic [47:0] exp_q[$];
    int          exp_clk;
    int          exp_tmr;

    button_frontend #(
        .M_FREQ      (1000),
        .DEBOUNCE_MS (4),
        .HOLD_MS     (20),
        .REPEAT_MS   (10)
    ) dut (
        .mclk          (mclk),
        .rst_n         (rst_n),
        .pButton       (pButton),
        .pMode         (pMode),
        .pTimer        (pTimer),
        .vButton       (vButton),
        .clk_mode      (clk_mode),
        .timer_mode    (timer_mode),
        .dbg_rpt_state (dbg_rpt_state)
    );

    // clock / reset
    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // monitor: every nonzero vButton must match the head of the expected queue
    initial begin
        cyc = 0;
        forever begin
            @(posedge mclk);
            cyc++;
            #1;
            if (vButton != 6'd0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {32'(cyc), 16'(vButton)}, 64'd0);
                end else begin
                    check("pulse", {16'd0, 32'(cyc), 16'(vButton)}, {16'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic push_pulse(input int edge_no, input logic [15:0] mask);
        exp_q.push_back({32'(edge_no), mask});
    endtask

    task automatic set_raw(input int ch, input logic v);
        if (ch < 6) pButton[ch] = v;
        else if (ch == 6) pMode = v;
        else pTimer = v;
    endtask

    // Raw input set just before edge e; pulse at e+5, repeats while d < hold.
    task automatic press_btn(input int ch, input int hold);
        int e;
        logic [15:0] m;
        @(negedge mclk);
        e = cyc + 1;
        set_raw(ch, 1'b1);
        if (ch < 6) begin
            m = 16'd1 << ch;
            push_pulse(e + 5, m);
            if (ch < 3) begin
                for (int d = 20; d < hold; d += 10) push_pulse(e + 5 + d, m);
            end
        end
        repeat (hold) @(negedge mclk);
        set_raw(ch, 1'b0);
        repeat (8) @(negedge mclk);
    endtask

    task automatic mode_press(input int ch, input string tag);
        press_btn(ch, 6);
        if (ch == 6 && exp_tmr == 0) exp_clk = (exp_clk + 1) % 4;
        else if (ch == 7 && exp_clk == 0) exp_tmr = (exp_tmr == 2) ? 0 : exp_tmr + 1;
        check({tag, "_clk_mode"}, 64'(clk_mode), 64'(exp_clk));
        check({tag, "_timer_mode"}, 64'(timer_mode), 64'(exp_tmr));
    endtask

    initial begin
        #1000000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        int e;
        n_cmp   = 0;
        n_err   = 0;
        exp_clk = 0;
        exp_tmr = 0;
        rst_n   = 1'b0;
        pButton = '0;
        pMode   = 1'b0;
        pTimer  = 1'b0;
        repeat (3) @(negedge mclk);
        check("rst_vbutton", 64'(vButton), 64'd0);
        check("rst_clk_mode", 64'(clk_mode), 64'd0);
        check("rst_timer_mode", 64'(timer_mode), 64'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge mclk);

        // clean press, no repeat within 8 cycles
        press_btn(0, 8);

        // bounce: 1,0,1,0 every 2 cycles, then stable high
        @(negedge mclk);
        pButton[4] = 1'b1;
        repeat (2) @(negedge mclk);
        pButton[4] = 1'b0;
        repeat (2) @(negedge mclk);
        pButton[4] = 1'b1;
        repeat (2) @(negedge mclk);
        pButton[4] = 1'b0;
        repeat (2) @(negedge mclk);
        e = cyc + 1;
        pButton[4] = 1'b1;
        push_pulse(e + 5, 16'h0010);
        repeat (10) @(negedge mclk);
        pButton[4] = 1'b0;
        repeat (8) @(negedge mclk);

        // auto-repeat on bit 1, none on bit 3
        press_btn(1, 60);
        press_btn(3, 60);
        press_btn(5, 6);
        press_btn(2, 6);

        // two channels pulsing together
        @(negedge mclk);
        e = cyc + 1;
        pButton[0] = 1'b1;
        pButton[5] = 1'b1;
        push_pulse(e + 5, 16'h0021);
        repeat (6) @(negedge mclk);
        pButton = '0;
        repeat (8) @(negedge mclk);

        // mode cycling and interlocks
        for (int k = 0; k < 5; k++) mode_press(6, "mode_cycle");
        mode_press(7, "timer_blocked");
        for (int k = 0; k < 3; k++) mode_press(6, "mode_back");
        for (int k = 0; k < 3; k++) mode_press(7, "timer_cycle");
        mode_press(7, "timer_one");
        mode_press(6, "mode_blocked");
        mode_press(7, "timer_two");
        mode_press(7, "timer_zero");

        // simultaneous mode + timer presses with both modes idle
        @(negedge mclk);
        pMode  = 1'b1;
        pTimer = 1'b1;
        repeat (6) @(negedge mclk);
        pMode  = 1'b0;
        pTimer = 1'b0;
        repeat (8) @(negedge mclk);
        exp_clk = 1;
        check("simul_clk_mode", 64'(clk_mode), 64'(exp_clk));
        check("simul_timer_mode", 64'(timer_mode), 64'(exp_tmr));
        mode_press(6, "mode_two");

        // reset asserted mid-REPEAT while a repeat pulse is on vButton[2]
        @(negedge mclk);
        e = cyc + 1;
        pButton[2] = 1'b1;
        push_pulse(e + 5, 16'h0004);
        push_pulse(e + 25, 16'h0004);
        push_pulse(e + 35, 16'h0004);
        while (cyc < e + 35) @(negedge mclk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_vbutton", 64'(vButton), 64'd0);
        check("async_rst_clk_mode", 64'(clk_mode), 64'd0);
        check("async_rst_timer_mode", 64'(timer_mode), 64'd0);
        exp_clk = 0;
        exp_tmr = 0;
        repeat (3) @(negedge mclk);
        rst_n = 1'b1;
        e = cyc + 1;
        push_pulse(e + 5, 16'h0004);
        push_pulse(e + 25, 16'h0004);
        push_pulse(e + 35, 16'h0004);
        repeat (40) @(negedge mclk);
        pButton[2] = 1'b0;
        repeat (12) @(negedge mclk);
        check("post_rst_clk_mode", 64'(clk_mode), 64'd0);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
